// File: rtl/uart_tx_peripheral_if.sv
// Register-access bus for the UART transmitter peripheral.
// The master drives select, strobe, offset and write data; the slave returns read data.
interface uart_tx_peripheral_if;
    logic       cs;
    logic       we;
    logic [1:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output cs,
        output we,
        output addr,
        output data_in,
        input  data_out
    );

    modport slave (
        input  cs,
        input  we,
        input  addr,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/uart_tx_peripheral.sv
// UART transmitter with CONFIG/STATUS/DATA/COMMAND registers and a one-byte holding buffer.
// Frames are 8N1, LSB first, each bit held for CLK_FREQ_HZ/BAUD_RATE clocks.
module uart_tx_peripheral #(
    parameter int unsigned CLK_FREQ_HZ = 20000000,
    parameter int unsigned BAUD_RATE   = 115200
) (
    input  logic                 clk,
    input  logic                 reset_n,
    uart_tx_peripheral_if.slave  bus,
    output logic                 tx_serial,
    output logic                 tx_busy
);

    localparam int unsigned CLKS_RAW     = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned CLKS_PER_BIT = (CLKS_RAW < 2) ? 2 : CLKS_RAW;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] ADDR_CONFIG  = 2'b00;
    localparam logic [1:0] ADDR_STATUS  = 2'b01;
    localparam logic [1:0] ADDR_DATA    = 2'b10;
    localparam logic [1:0] ADDR_COMMAND = 2'b11;

    typedef enum logic [1:0] {
        S_UART_TX_IDLE      = 2'b00,
        S_UART_TX_START     = 2'b01,
        S_UART_TX_SEND_DATA = 2'b10,
        S_UART_TX_STOP      = 2'b11
    } uart_fsm_state_t;

    uart_fsm_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic             overrun_q, overrun_d;
    logic             tx_en_q, tx_en_d;
    logic             tx_serial_q, tx_serial_d;

    logic wr, data_wr, cfg_wr, cmd_wr, take, cnt_done;

    always_comb begin
        wr       = bus.cs && bus.we;
        cfg_wr   = wr && (bus.addr == ADDR_CONFIG);
        data_wr  = wr && (bus.addr == ADDR_DATA);
        cmd_wr   = wr && (bus.addr == ADDR_COMMAND);
        take     = (state_q == S_UART_TX_IDLE) && buf_full_q && tx_en_q;
        cnt_done = (cnt_q == CNT_LAST);

        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        overrun_d  = overrun_q;
        tx_en_d    = tx_en_q;

        case (state_q)
            S_UART_TX_IDLE: begin
                if (take) begin
                    shift_d = buf_q;
                    cnt_d   = '0;
                    state_d = S_UART_TX_START;
                end
            end
            S_UART_TX_START: begin
                if (cnt_done) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = S_UART_TX_SEND_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_UART_TX_SEND_DATA: begin
                if (cnt_done) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_UART_TX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_UART_TX_STOP: begin
                if (cnt_done) begin
                    cnt_d   = '0;
                    state_d = S_UART_TX_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_UART_TX_IDLE;
        endcase

        // A write landing on the same edge the FSM drains the buffer refills it cleanly.
        if (take) begin
            buf_full_d = 1'b0;
        end
        if (data_wr) begin
            if (!buf_full_q || take) begin
                buf_d      = bus.data_in;
                buf_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (cmd_wr && bus.data_in[0]) begin
            overrun_d = 1'b0;
        end
        if (cfg_wr) begin
            tx_en_d = bus.data_in[0];
        end

        // Line level follows the next state so the output flop lines up with the state flop.
        case (state_d)
            S_UART_TX_START:     tx_serial_d = 1'b0;
            S_UART_TX_SEND_DATA: tx_serial_d = shift_d[0];
            default:             tx_serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_UART_TX_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            overrun_q   <= 1'b0;
            tx_en_q     <= 1'b1;
            tx_serial_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            overrun_q   <= overrun_d;
            tx_en_q     <= tx_en_d;
            tx_serial_q <= tx_serial_d;
        end
    end

    assign tx_serial = tx_serial_q;
    assign tx_busy   = (state_q != S_UART_TX_IDLE);

    always_comb begin
        bus.data_out = '0;
        if (bus.cs && !bus.we) begin
            case (bus.addr)
                ADDR_CONFIG: bus.data_out = {7'b0, tx_en_q};
                ADDR_STATUS: bus.data_out = {5'b0, overrun_q, buf_full_q, tx_busy};
                default:     bus.data_out = '0;
            endcase
        end
    end

endmodule
